// File: rtl/modulo_condicionador_botoes.sv
// Per-channel button conditioner: two-flop synchroniser, debounce, registered
// press/release pulses and an auto-repeat pulse train that includes the press.
module modulo_condicionador_botoes #(
    parameter int N_CH         = 3,
    parameter int STABLE       = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 3
) (
    input  logic            clk_i,
    input  logic            clr_i,
    input  logic [N_CH-1:0] btn_n_i,
    output logic [N_CH-1:0] lvl_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] rpt_o
);

    localparam int CW   = $clog2(STABLE) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
    localparam bit            RPT_EN    = (REPEAT_DELAY > 0);
    localparam logic [RW-1:0] DLY_LOAD  = RPT_EN ? RW'(REPEAT_DELAY - 1) : '0;
    localparam logic [RW-1:0] RATE_LOAD = RW'(REPEAT_RATE - 1);

    logic [N_CH-1:0] s1_q, s2_q;
    logic [N_CH-1:0] lvl_q, lvl_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] rpt_q, rpt_d;
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [RW-1:0]   rcnt_q [N_CH];
    logic [RW-1:0]   rcnt_d [N_CH];

    logic [N_CH-1:0] mismatch_w;
    logic [N_CH-1:0] toggle_w;

    // Candidate level is the inverted synchronised pin; mismatch drives the debounce.
    assign mismatch_w = (~s2_q) ^ lvl_q;

    always_comb begin
        toggle_w  = '0;
        lvl_d     = lvl_q;
        press_d   = '0;
        release_d = '0;
        rpt_d     = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch]  = '0;
            rcnt_d[ch] = '0;

            toggle_w[ch] = mismatch_w[ch] && (cnt_q[ch] == CNT_LAST);
            if (mismatch_w[ch] && !toggle_w[ch]) begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end

            if (toggle_w[ch]) begin
                lvl_d[ch]     = ~lvl_q[ch];
                press_d[ch]   = ~lvl_q[ch];
                release_d[ch] = lvl_q[ch];
            end

            // Repeat counter counts down to zero, firing and reloading with the rate.
            // Firing is blocked on the release edge so rpt never shows with lvl low.
            if (toggle_w[ch] && !lvl_q[ch]) begin
                rpt_d[ch]  = 1'b1;
                rcnt_d[ch] = DLY_LOAD;
            end else if (RPT_EN && lvl_q[ch] && !toggle_w[ch]) begin
                if (rcnt_q[ch] == '0) begin
                    rpt_d[ch]  = 1'b1;
                    rcnt_d[ch] = RATE_LOAD;
                end else begin
                    rcnt_d[ch] = rcnt_q[ch] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            s1_q      <= '1;
            s2_q      <= '1;
            lvl_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            rpt_q     <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch]  <= '0;
                rcnt_q[ch] <= '0;
            end
        end else begin
            s1_q      <= btn_n_i;
            s2_q      <= s1_q;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch]  <= cnt_d[ch];
                rcnt_q[ch] <= rcnt_d[ch];
            end
        end
    end

    assign lvl_o     = lvl_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign rpt_o     = rpt_q;

endmodule
